sbox_share_sched: RTL and testbench

//  Time-multiplexes one shared 32-bit S-box (sbox_32bits, 2-cycle registered latency) between two requesters.
//  The requesters are the round datapath (128-bit SubBytes) and the key expansion (32-bit SubWord).
//  The block arbitrates requests, issues 32-bit words to the S-box and tracks in-flight words with a tag pipeline.
//  It reassembles results and returns them to the requester that issued them.

---
 rtl/sbox_share_sched_if.sv | 36 +++
 rtl/sbox_share_sched.sv | 163 ++++++++++++++++
 tb/tb_sbox_share_sched.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sbox_share_sched_if.sv
// sbox_share_sched_if
//   Bundles the request/response handshakes of the round-state and key-word
//   requesters together with the shared S-box data path.
//   slave  : the scheduler side (drives readies, results and sbox_in)
//   master : the requester / S-box side (drives requests and sbox_out)
//   st_*   : 128-bit SubBytes request (st_req_valid/ready, st_in) and result
//            (st_out_valid pulse, st_out held)
//   kw_*   : 32-bit SubWord request (kw_req_valid/ready, kw_in) and result
//            (kw_out_valid pulse, kw_out held)
//   sbox_in / sbox_out : word to / from the shared sbox_32bits instance
interface sbox_share_sched_if;
    logic         st_req_valid;
    logic         st_req_ready;
    logic [127:0] st_in;
    logic         st_out_valid;
    logic [127:0] st_out;
    logic         kw_req_valid;
    logic         kw_req_ready;
    logic [31:0]  kw_in;
    logic         kw_out_valid;
    logic [31:0]  kw_out;
    logic [31:0]  sbox_in;
    logic [31:0]  sbox_out;

    modport slave (
        input  st_req_valid, st_in, kw_req_valid, kw_in, sbox_out,
        output st_req_ready, st_out_valid, st_out,
        output kw_req_ready, kw_out_valid, kw_out, sbox_in
    );

    modport master (
        output st_req_valid, st_in, kw_req_valid, kw_in, sbox_out,
        input  st_req_ready, st_out_valid, st_out,
        input  kw_req_ready, kw_out_valid, kw_out, sbox_in
    );
endinterface

// File: rtl/sbox_share_sched.sv
// sbox_share_sched
//   Time-multiplexes one shared 32-bit S-box (SBOX_LAT-cycle registered
//   latency) between the round datapath (128-bit SubBytes, four words) and
//   the key expansion (32-bit SubWord). Requests are arbitrated round-robin
//   per transaction, words are issued one per cycle with a tag pipeline
//   tracking them, and results are reassembled and returned to the issuer.
//   Ports:
//     clk   : clock, rising edge
//     rst_n : asynchronous active-low reset
//     bus   : sbox_share_sched_if.slave (request/response handshakes and
//             the shared S-box in/out words)
module sbox_share_sched #(
    parameter int unsigned SBOX_LAT = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    sbox_share_sched_if.slave   bus
);

    typedef enum logic [1:0] {IDLE, ST_ISSUE, KW_ISSUE} state_t;
    typedef enum logic {SRC_ST = 1'b0, SRC_KW = 1'b1} src_t;

    state_t                  state;
    logic [1:0]              cnt;
    src_t                    last_grant;
    logic                    st_pending;
    logic                    kw_pending;
    logic [95:0]             st_rest;    // words 1..3; word0 goes straight to the S-box on accept
    logic [95:0]             st_acc;     // results of words 0..2 until word 3 arrives
    logic [SBOX_LAT:0]       tag_v;
    logic [SBOX_LAT:0]       tag_kw;
    logic [SBOX_LAT:0][1:0]  tag_idx;

    logic        st_elig, kw_elig, grant_st, grant_kw;
    logic        st_fire, kw_fire;
    logic        push_v, push_kw;
    logic [1:0]  push_idx;
    logic [31:0] sbox_nxt;
    logic [31:0] next_word;

    // Arbitration: a lone eligible requester wins; on a tie the one that did
    // not win last time is granted.
    always_comb begin
        st_elig  = bus.st_req_valid & ~st_pending;
        kw_elig  = bus.kw_req_valid & ~kw_pending;
        grant_st = st_elig & (~kw_elig | (last_grant == SRC_KW));
        grant_kw = kw_elig & (~st_elig | (last_grant == SRC_ST));
    end

    // Readiness only in IDLE; reset term keeps it low while reset is held.
    assign bus.st_req_ready = rst_n & (state == IDLE) & grant_st;
    assign bus.kw_req_ready = rst_n & (state == IDLE) & grant_kw;
    assign st_fire = bus.st_req_valid & bus.st_req_ready;
    assign kw_fire = bus.kw_req_valid & bus.kw_req_ready;

    always_comb begin
        case (cnt)
            2'd0:    next_word = st_rest[95:64];
            2'd1:    next_word = st_rest[63:32];
            default: next_word = st_rest[31:0];
        endcase
    end

    // sbox_in is registered, so the word issued in a state is loaded on the
    // edge entering it; the tag pushed with it enters stage 0 on the same edge,
    // which keeps stage SBOX_LAT aligned with sbox_out.
    always_comb begin
        push_v   = 1'b0;
        push_kw  = 1'b0;
        push_idx = '0;
        sbox_nxt = '0;
        case (state)
            IDLE: begin
                if (st_fire) begin
                    push_v   = 1'b1;
                    sbox_nxt = bus.st_in[127:96];
                end else if (kw_fire) begin
                    push_v   = 1'b1;
                    push_kw  = 1'b1;
                    sbox_nxt = bus.kw_in;
                end
            end
            ST_ISSUE: begin
                if (cnt != 2'd3) begin
                    push_v   = 1'b1;
                    push_idx = cnt + 2'd1;
                    sbox_nxt = next_word;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            cnt              <= '0;
            last_grant       <= SRC_KW;
            st_pending       <= 1'b0;
            kw_pending       <= 1'b0;
            st_rest          <= '0;
            st_acc           <= '0;
            tag_v            <= '0;
            tag_kw           <= '0;
            tag_idx          <= '0;
            bus.sbox_in      <= '0;
            bus.st_out       <= '0;
            bus.st_out_valid <= 1'b0;
            bus.kw_out       <= '0;
            bus.kw_out_valid <= 1'b0;
        end else begin
            tag_v       <= {tag_v[SBOX_LAT-1:0], push_v};
            tag_kw      <= {tag_kw[SBOX_LAT-1:0], push_kw};
            tag_idx     <= {tag_idx[SBOX_LAT-1:0], push_idx};
            bus.sbox_in <= sbox_nxt;

            // Pending drops one cycle after the result pulse.
            if (bus.st_out_valid) st_pending <= 1'b0;
            if (bus.kw_out_valid) kw_pending <= 1'b0;

            case (state)
                IDLE: begin
                    if (st_fire) begin
                        st_rest    <= bus.st_in[95:0];
                        st_pending <= 1'b1;
                        last_grant <= SRC_ST;
                        cnt        <= 2'd0;
                        state      <= ST_ISSUE;
                    end else if (kw_fire) begin
                        kw_pending <= 1'b1;
                        last_grant <= SRC_KW;
                        state      <= KW_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (cnt == 2'd3) state <= IDLE;
                    else             cnt   <= cnt + 2'd1;
                end
                default: state <= IDLE;
            endcase

            bus.st_out_valid <= 1'b0;
            bus.kw_out_valid <= 1'b0;
            if (tag_v[SBOX_LAT]) begin
                if (tag_kw[SBOX_LAT]) begin
                    bus.kw_out       <= bus.sbox_out;
                    bus.kw_out_valid <= 1'b1;
                end else begin
                    case (tag_idx[SBOX_LAT])
                        2'd0: st_acc[95:64] <= bus.sbox_out;
                        2'd1: st_acc[63:32] <= bus.sbox_out;
                        2'd2: st_acc[31:0]  <= bus.sbox_out;
                        default: begin
                            bus.st_out       <= {st_acc, bus.sbox_out};
                            bus.st_out_valid <= 1'b1;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_sbox_share_sched.sv
module tb_sbox_share_sched;

    localparam int unsigned SBOX_LAT = 2;
    localparam int ST_LAT = SBOX_LAT + 5;
    localparam int KW_LAT = SBOX_LAT + 2;

    localparam logic [0:255][7:0] SBOX_T = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    sbox_share_sched_if bus();

    sbox_share_sched #(.SBOX_LAT(SBOX_LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) r[8*b +: 8] = SBOX_T[w[8*b +: 8]];
        return r;
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        return {sub_word(s[127:96]), sub_word(s[95:64]), sub_word(s[63:32]), sub_word(s[31:0])};
    endfunction

    // Shared S-box stand-in: two register stages, no reset.
    logic [31:0] sb_r1 = '0;
    logic [31:0] sb_r2 = '0;
    always @(posedge clk) begin
        sb_r1 <= sub_word(bus.sbox_in);
        sb_r2 <= sb_r1;
    end
    assign bus.sbox_out = sb_r2;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    logic [127:0] st_exp_q[$];
    int           st_acc_q[$];
    logic [31:0]  kw_exp_q[$];
    int           kw_acc_q[$];
    int           grant_log[$];   // 1 = ST accepted, 2 = KW accepted
    int           last_st_acc;
    int           last_kw_acc;

    // Scoreboard consumer: pops on every result pulse.
    always @(negedge clk) begin : mon
        logic [127:0] e;
        int           a;
        if (rst_n) begin
            if (bus.st_out_valid) begin
                if (st_exp_q.size() == 0) begin
                    check_val("st_unexpected_pulse", 128'(bus.st_out_valid), 128'(0));
                end else begin
                    e = st_exp_q.pop_front();
                    a = st_acc_q.pop_front();
                    check_val("st_out", bus.st_out, e);
                    check_val("st_latency", 128'(cyc - a), 128'(ST_LAT));
                end
            end
            if (bus.kw_out_valid) begin
                if (kw_exp_q.size() == 0) begin
                    check_val("kw_unexpected_pulse", 128'(bus.kw_out_valid), 128'(0));
                end else begin
                    e = 128'(kw_exp_q.pop_front());
                    a = kw_acc_q.pop_front();
                    check_val("kw_out", 128'(bus.kw_out), e);
                    check_val("kw_latency", 128'(cyc - a), 128'(KW_LAT));
                end
            end
        end
    end

    // Raises valid with new data and waits for acceptance; valid is left high.
    task automatic st_send(input logic [127:0] d, input logic [127:0] exp);
        @(negedge clk);
        bus.st_in        = d;
        bus.st_req_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            #1;
            if (bus.st_req_ready) begin
                st_exp_q.push_back(exp);
                st_acc_q.push_back(cyc);
                last_st_acc = cyc;
                grant_log.push_back(1);
                @(posedge clk);
                return;
            end
            @(negedge clk);
        end
        check_val("st_accept_timeout", 128'(bus.st_req_ready), 128'(1));
    endtask

    task automatic kw_send(input logic [31:0] d, input logic [31:0] exp);
        @(negedge clk);
        bus.kw_in        = d;
        bus.kw_req_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            #1;
            if (bus.kw_req_ready) begin
                kw_exp_q.push_back(exp);
                kw_acc_q.push_back(cyc);
                last_kw_acc = cyc;
                grant_log.push_back(2);
                @(posedge clk);
                return;
            end
            @(negedge clk);
        end
        check_val("kw_accept_timeout", 128'(bus.kw_req_ready), 128'(1));
    endtask

    task automatic drop_valids();
        @(negedge clk);
        bus.st_req_valid = 1'b0;
        bus.kw_req_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 300; i++) begin
            if (st_exp_q.size() == 0 && kw_exp_q.size() == 0) return;
            @(negedge clk);
        end
        check_val("drain_timeout", 128'(st_exp_q.size() + kw_exp_q.size()), 128'(0));
    endtask

    task automatic check_all_zero(input string pfx);
        check_val({pfx, "_st_out"},       bus.st_out, '0);
        check_val({pfx, "_kw_out"},       128'(bus.kw_out), '0);
        check_val({pfx, "_sbox_in"},      128'(bus.sbox_in), '0);
        check_val({pfx, "_st_out_valid"}, 128'(bus.st_out_valid), '0);
        check_val({pfx, "_kw_out_valid"}, 128'(bus.kw_out_valid), '0);
        check_val({pfx, "_st_req_ready"}, 128'(bus.st_req_ready), '0);
        check_val({pfx, "_kw_req_ready"}, 128'(bus.kw_req_ready), '0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.st_req_valid = 1'b0;
        bus.kw_req_valid = 1'b0;
        rst_n = 1'b0;
        st_exp_q.delete();
        st_acc_q.delete();
        kw_exp_q.delete();
        kw_acc_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [127:0] d;
        logic [31:0]  k;
        int           t1;

        bus.st_req_valid = 1'b0;
        bus.kw_req_valid = 1'b0;
        bus.st_in        = '0;
        bus.kw_in        = '0;

        // Reset state
        #2 rst_n = 1'b0;
        #1 check_all_zero("rst");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // 1: SubBytes vector
        st_send(128'h00112233445566778899aabbccddeeff, 128'h638293c31bfc33f5c4eeacea4bc12816);
        drop_valids();
        drain();

        // 2: SubWord vectors
        kw_send(32'hcf4f3c09, 32'h8a84eb01);
        drop_valids();
        drain();
        kw_send(32'h00000000, 32'h63636363);
        drop_valids();
        drain();

        // 3: both requesters continuously valid after reset
        do_reset();
        grant_log.delete();
        fork
            begin
                d = {$urandom, $urandom, $urandom, $urandom};
                st_send(d, sub_bytes(d));
                d = {$urandom, $urandom, $urandom, $urandom};
                st_send(d, sub_bytes(d));
                @(negedge clk);
                bus.st_req_valid = 1'b0;
            end
            begin
                k = $urandom;
                kw_send(k, sub_word(k));
                @(negedge clk);
                bus.kw_req_valid = 1'b0;
            end
        join
        drain();
        check_val("grant_count", 128'(grant_log.size()), 128'(3));
        if (grant_log.size() == 3) begin
            check_val("grant0_st", 128'(grant_log[0]), 128'(1));
            check_val("grant1_kw", 128'(grant_log[1]), 128'(2));
            check_val("grant2_st", 128'(grant_log[2]), 128'(1));
        end

        // 4: ST valid held with new data while the first job is pending
        d = {$urandom, $urandom, $urandom, $urandom};
        st_send(d, sub_bytes(d));
        t1 = last_st_acc;
        d = {$urandom, $urandom, $urandom, $urandom};
        st_send(d, sub_bytes(d));
        check_val("st_hold_gap", 128'(last_st_acc - t1), 128'(ST_LAT + 1));
        drop_valids();
        drain();

        // 5: reset while ST_ISSUE is at cnt=2
        st_send(128'h0123456789abcdeffedcba9876543210, 128'h0);
        repeat (3) @(negedge clk);
        bus.st_req_valid = 1'b0;
        rst_n = 1'b0;
        #1 check_all_zero("midrst");
        st_exp_q.delete();
        st_acc_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        kw_send(32'hffffffff, 32'h16161616);
        drop_valids();
        drain();

        // 6: back-to-back KW
        kw_send(32'h01010101, 32'h7c7c7c7c);
        t1 = last_kw_acc;
        kw_send(32'h53535353, 32'hedededed);
        check_val("kw_b2b_gap", 128'(last_kw_acc - t1), 128'(KW_LAT + 1));
        drop_valids();
        drain();

        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
